// File: rtl/router_pkt_tx.sv
// Packet transmitter for the router input port: buffers payload bytes, then sends
// header, payload and an even-XOR parity byte with backpressure via busy.
module router_pkt_tx #(
  parameter int MAX_LEN = 63
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] payload_len,
  input  logic       inject_err,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEADER  = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] PARITY  = 2'd3;

  localparam logic [5:0] MAX_LEN_C = 6'(MAX_LEN);

  logic [1:0] state;
  logic [5:0] wr_count;
  logic [5:0] rd_idx;
  logic [5:0] len_q;
  logic       inj_q;
  logic [7:0] parity;
  logic [7:0] buf_mem [MAX_LEN];

  logic       start_bad;
  logic       buf_wr;
  logic [7:0] parity_next;

  // A start in the same cycle as a write blocks the write, so the length check
  // always sees the pre-write count.
  assign start_bad   = (payload_len == 6'd0) || (dest_addr == 2'd3) || (payload_len != wr_count);
  assign buf_wr      = (state == IDLE) && wr_en && !start && (wr_count < MAX_LEN_C);
  assign parity_next = parity ^ data_out;
  assign tx_ready    = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rstn && buf_wr) begin
      buf_mem[wr_count] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      data_out  <= 8'h00;
      pkt_valid <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      wr_count  <= 6'd0;
      rd_idx    <= 6'd0;
      parity    <= 8'h00;
      len_q     <= 6'd0;
      inj_q     <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (start_bad) begin
              tx_err <= 1'b1;
            end else begin
              len_q     <= payload_len;
              inj_q     <= inject_err;
              data_out  <= {payload_len, dest_addr};
              parity    <= {payload_len, dest_addr};
              pkt_valid <= 1'b1;
              state     <= HEADER;
            end
          end else if (buf_wr) begin
            wr_count <= wr_count + 6'd1;
          end
        end
        HEADER: begin
          if (!busy) begin
            data_out <= buf_mem[0];
            rd_idx   <= 6'd0;
            state    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!busy) begin
            parity <= parity_next;
            if (rd_idx < len_q - 6'd1) begin
              rd_idx   <= rd_idx + 6'd1;
              data_out <= buf_mem[rd_idx + 6'd1];
            end else begin
              pkt_valid <= 1'b0;
              data_out  <= inj_q ? ~parity_next : parity_next;
              state     <= PARITY;
            end
          end
        end
        PARITY: begin
          if (!busy) begin
            data_out <= 8'h00;
            tx_done  <= 1'b1;
            wr_count <= 6'd0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: directed packets push expected bytes and
// pulses into a queue; a negedge monitor pops and compares every transfer.
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       start = 1'b0;
  logic [1:0] dest_addr = 2'd0;
  logic [5:0] payload_len = 6'd0;
  logic       inject_err = 1'b0;
  logic       busy = 1'b0;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;

  localparam logic [1:0] K_BYTE = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  int n_checks = 0;
  int n_fails  = 0;
  logic [10:0] exp_q[$];

  router_pkt_tx #(.MAX_LEN(63)) dut (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .dest_addr(dest_addr), .payload_len(payload_len), .inject_err(inject_err),
    .busy(busy), .data_out(data_out), .pkt_valid(pkt_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic sb_pop(input logic [10:0] actual);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL scoreboard: unexpected output 0x%0h with empty queue at %0t", actual, $time);
    end else begin
      check_output("scoreboard", 32'(actual), 32'(exp_q.pop_front()));
    end
  endtask

  // Monitor: a byte counts as transferred when presented with busy low before the edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (tx_done) sb_pop({K_DONE, 1'b0, 8'h00});
      if (tx_err)  sb_pop({K_ERR, 1'b0, 8'h00});
      if (!tx_ready && !busy) sb_pop({K_BYTE, pkt_valid, data_out});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      wr_en   = 1'b1;
      wr_data = bytes[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic push_pkt(input logic [5:0] len, input logic [1:0] addr,
                          input logic [7:0] pay[$], input logic [7:0] par);
    exp_q.push_back({K_BYTE, 1'b1, len, addr});
    foreach (pay[i]) exp_q.push_back({K_BYTE, 1'b1, pay[i]});
    exp_q.push_back({K_BYTE, 1'b0, par});
    exp_q.push_back({K_DONE, 1'b0, 8'h00});
  endtask

  task automatic apply_stimulus(input logic [5:0] len, input logic [1:0] addr, input logic inj,
                                input int stall_val, input int stall_n, output int held);
    int left;
    int cycles;
    payload_len = len;
    dest_addr   = addr;
    inject_err  = inj;
    start       = 1'b1;
    tick();
    start      = 1'b0;
    inject_err = 1'b0;
    held   = 0;
    left   = stall_n;
    cycles = 0;
    while (!tx_ready && cycles < 200) begin
      busy = 1'b0;
      if (stall_val >= 0 && pkt_valid && data_out == stall_val[7:0]) begin
        held++;
        if (left > 0) begin
          busy = 1'b1;
          left--;
        end
      end
      tick();
      cycles++;
    end
    busy = 1'b0;
    check_output("pkt_complete", 32'(cycles < 200), 32'd1);
  endtask

  task automatic reject_start(input logic [5:0] len, input logic [1:0] addr,
                              input logic we, input logic [7:0] wd);
    exp_q.push_back({K_ERR, 1'b0, 8'h00});
    payload_len = len;
    dest_addr   = addr;
    wr_en       = we;
    wr_data     = wd;
    start       = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check_output("reject_pkt_valid", 32'(pkt_valid), 32'd0);
    check_output("reject_tx_ready", 32'(tx_ready), 32'd1);
    tick();
  endtask

  initial begin
    logic [7:0] pay[$];
    logic [7:0] pay5[$];
    int held;
    int cycles;

    pay5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // Reset values
    #2;
    check_output("reset_data_out", 32'(data_out), 32'h00);
    check_output("reset_pkt_valid", 32'(pkt_valid), 32'd0);
    check_output("reset_tx_ready", 32'(tx_ready), 32'd1);
    check_output("reset_tx_done", 32'(tx_done), 32'd0);
    check_output("reset_tx_err", 32'(tx_err), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    $display("[TB] basic 5-byte packet");
    write_list(pay5);
    push_pkt(6'd5, 2'd2, pay5, 8'h07);
    apply_stimulus(6'd5, 2'd2, 1'b0, -1, 0, held);

    $display("[TB] backpressure on 0x22");
    write_list(pay5);
    push_pkt(6'd5, 2'd2, pay5, 8'h07);
    apply_stimulus(6'd5, 2'd2, 1'b0, 32'h22, 3, held);
    check_output("stall_hold_cycles", 32'(held), 32'd4);

    $display("[TB] injected parity error");
    write_list(pay5);
    push_pkt(6'd5, 2'd2, pay5, 8'hF8);
    apply_stimulus(6'd5, 2'd2, 1'b1, -1, 0, held);

    $display("[TB] rejected starts");
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_list(pay);
    reject_start(6'd5, 2'd2, 1'b1, 8'h55);
    pay = '{8'h55};
    write_list(pay);
    reject_start(6'd5, 2'd3, 1'b0, 8'h00);
    reject_start(6'd0, 2'd2, 1'b0, 8'h00);
    reject_start(6'd4, 2'd2, 1'b0, 8'h00);
    push_pkt(6'd5, 2'd2, pay5, 8'h07);
    apply_stimulus(6'd5, 2'd2, 1'b0, -1, 0, held);

    $display("[TB] reset mid-packet");
    write_list(pay5);
    exp_q.push_back({K_BYTE, 1'b1, 8'h16});
    exp_q.push_back({K_BYTE, 1'b1, 8'h11});
    exp_q.push_back({K_BYTE, 1'b1, 8'h22});
    exp_q.push_back({K_BYTE, 1'b1, 8'h33});
    payload_len = 6'd5;
    dest_addr   = 2'd2;
    start       = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 0;
    while (!(pkt_valid && data_out == 8'h44) && cycles < 50) begin
      tick();
      cycles++;
    end
    check_output("abort_reached_4th", 32'(cycles < 50), 32'd1);
    rstn = 1'b0;
    #1;
    check_output("abort_data_out", 32'(data_out), 32'h00);
    check_output("abort_pkt_valid", 32'(pkt_valid), 32'd0);
    check_output("abort_tx_ready", 32'(tx_ready), 32'd1);
    tick();
    rstn = 1'b1;
    tick();
    check_output("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    pay = '{8'hA5};
    write_list(pay);
    push_pkt(6'd1, 2'd0, pay, 8'hA1);
    apply_stimulus(6'd1, 2'd0, 1'b0, -1, 0, held);

    $display("[TB] maximum length packet");
    pay.delete();
    for (int i = 1; i <= 63; i++) pay.push_back(8'(i));
    write_list(pay);
    pay5 = '{8'h40};
    write_list(pay5);
    push_pkt(6'd63, 2'd1, pay, 8'hFD);
    apply_stimulus(6'd63, 2'd1, 1'b0, -1, 0, held);

    repeat (3) tick();
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
